te_block_tracker: RTL and testbench

- Multi-retire, parametrised successor to the single-port itype/iretire tracker in the trace encoder connector.
- Consumes up to NRET committed instructions per cycle plus one trap event per cycle. Groups retired instructions into blocks and emits one descriptor per block: iaddr, iretire, ilastsize, itype, cause, tval, priv.
- Adds counter-saturation splitting and a FIFO output buffer with valid/ready handshake.
- Sits between the commit-port adapter and the trace encoder packetiser.

---
 rtl/te_block_tracker.sv | 191 +++++++++++++++++++
 tb/tb_te_block_tracker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_block_tracker.sv
// Groups up to NRET retired instructions plus one trap per cycle into trace blocks and
// queues one descriptor per block in a valid/ready FIFO for the encoder packetiser.
module te_block_tracker #(
  parameter int unsigned NRET        = 2,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned IRETIRE_LEN = 8,
  parameter int unsigned CAUSE_LEN   = 5,
  parameter int unsigned ITYPE_LEN   = 3,
  parameter int unsigned PRIV_LEN    = 2,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NRET-1:0]           lane_valid_i,
  input  logic [NRET*XLEN-1:0]      lane_pc_i,
  input  logic [NRET-1:0]           lane_compressed_i,
  input  logic [NRET*ITYPE_LEN-1:0] lane_itype_i,
  input  logic [NRET*PRIV_LEN-1:0]  lane_priv_i,
  input  logic                      trap_valid_i,
  input  logic [ITYPE_LEN-1:0]      trap_itype_i,
  input  logic [CAUSE_LEN-1:0]      cause_i,
  input  logic [XLEN-1:0]           tval_i,
  input  logic [PRIV_LEN-1:0]       trap_priv_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [XLEN-1:0]           iaddr_o,
  output logic [IRETIRE_LEN-1:0]    iretire_o,
  output logic                      ilastsize_o,
  output logic [ITYPE_LEN-1:0]      itype_o,
  output logic [CAUSE_LEN-1:0]      cause_o,
  output logic [XLEN-1:0]           tval_o,
  output logic [PRIV_LEN-1:0]       priv_o,
  output logic                      overflow_o
);

  localparam int unsigned MAX_PUSH = 2 * NRET + 1;
  localparam int unsigned PW       = $clog2(MAX_PUSH + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);

  localparam logic [IRETIRE_LEN:0]   CNT_MAX   = {1'b0, {IRETIRE_LEN{1'b1}}};
  localparam logic [IRETIRE_LEN:0]   SIZE_HALF = (IRETIRE_LEN + 1)'(1);
  localparam logic [IRETIRE_LEN:0]   SIZE_FULL = (IRETIRE_LEN + 1)'(2);
  localparam logic [ITYPE_LEN-1:0]   ITYPE_INT = ITYPE_LEN'(2);

  typedef enum logic {IDLE, COUNT} state_e;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } desc_t;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        base_q, base_d;
  logic [IRETIRE_LEN-1:0] count_q, count_d;
  logic                   last_q, last_d;

  desc_t                  push_desc [MAX_PUSH];
  logic [PW-1:0]          push_n;
  logic [IRETIRE_LEN:0]   lane_size;

  desc_t                  mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          fifo_cnt_q;
  logic                   overflow_q;
  logic                   pop;
  logic [PW-1:0]          accept;
  logic                   drop;
  int unsigned            free_slots;

  function automatic logic [AW-1:0] wrap_add(logic [AW-1:0] p, int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
    return AW'(s);
  endfunction

  // Lanes oldest-first, then the trap; each event may emit descriptors in generation order.
  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    last_d    = last_q;
    push_n    = '0;
    lane_size = '0;
    for (int unsigned i = 0; i < MAX_PUSH; i++) push_desc[i] = '0;

    for (int unsigned k = 0; k < NRET; k++) begin
      if (lane_valid_i[k]) begin
        if (state_d == IDLE) begin
          state_d = COUNT;
          base_d  = lane_pc_i[k*XLEN +: XLEN];
          count_d = '0;
        end
        lane_size = lane_compressed_i[k] ? SIZE_HALF : SIZE_FULL;
        if ({1'b0, count_d} + lane_size > CNT_MAX) begin
          push_desc[push_n] = '{base_d, count_d, last_d, '0, '0, '0,
                                lane_priv_i[k*PRIV_LEN +: PRIV_LEN]};
          push_n  = push_n + 1'b1;
          base_d  = lane_pc_i[k*XLEN +: XLEN];
          count_d = '0;
        end
        count_d = count_d + lane_size[IRETIRE_LEN-1:0];
        last_d  = !lane_compressed_i[k];
        if (lane_itype_i[k*ITYPE_LEN +: ITYPE_LEN] > ITYPE_INT) begin
          push_desc[push_n] = '{base_d, count_d, last_d,
                                lane_itype_i[k*ITYPE_LEN +: ITYPE_LEN], '0, '0,
                                lane_priv_i[k*PRIV_LEN +: PRIV_LEN]};
          push_n  = push_n + 1'b1;
          state_d = IDLE;
        end
      end
    end

    if (trap_valid_i) begin
      if (state_d == COUNT) begin
        push_desc[push_n] = '{base_d, count_d, last_d, trap_itype_i, cause_i,
                              (trap_itype_i == ITYPE_INT) ? '0 : tval_i, trap_priv_i};
      end else begin
        push_desc[push_n] = '{'0, '0, 1'b0, trap_itype_i, cause_i,
                              (trap_itype_i == ITYPE_INT) ? '0 : tval_i, trap_priv_i};
      end
      push_n  = push_n + 1'b1;
      state_d = IDLE;
    end
  end

  // Free space includes the slot released by a same-cycle pop; excess pushes drop youngest first.
  always_comb begin
    pop        = valid_o && ready_i;
    free_slots = FIFO_DEPTH - 32'(fifo_cnt_q) + 32'(pop);
    drop       = 1'b0;
    accept     = push_n;
    if (32'(push_n) > free_slots) begin
      accept = PW'(free_slots);
      drop   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      last_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      last_q     <= last_d;
      wr_ptr_q   <= wrap_add(wr_ptr_q, 32'(accept));
      rd_ptr_q   <= wrap_add(rd_ptr_q, 32'(pop));
      fifo_cnt_q <= fifo_cnt_q + CW'(accept) - CW'(pop);
      overflow_q <= overflow_q | drop;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count gates the outputs to zero when empty.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < MAX_PUSH; i++) begin
      if (PW'(i) < accept) mem_q[wrap_add(wr_ptr_q, i)] <= push_desc[i];
    end
  end

  desc_t head;
  always_comb begin
    valid_o = (fifo_cnt_q != '0);
    head    = valid_o ? mem_q[rd_ptr_q] : '0;
  end

  assign iaddr_o     = head.iaddr;
  assign iretire_o   = head.iretire;
  assign ilastsize_o = head.ilastsize;
  assign itype_o     = head.itype;
  assign cause_o     = head.cause;
  assign tval_o      = head.tval;
  assign priv_o      = head.priv;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_te_block_tracker.sv
// Directed test-plan steps followed by random traffic, checked against a queue-based
// block/FIFO reference model.
module tb_te_block_tracker;

  localparam int NRET = 2, XLEN = 64, IRL = 4, CL = 5, IL = 3, PL = 2, DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] iaddr;
    logic [IRL-1:0]  iretire;
    logic            ilastsize;
    logic [IL-1:0]   itype;
    logic [CL-1:0]   cause;
    logic [XLEN-1:0] tval;
    logic [PL-1:0]   priv;
  } desc_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NRET-1:0]      lane_valid, lane_compressed;
  logic [NRET*XLEN-1:0] lane_pc;
  logic [NRET*IL-1:0]   lane_itype;
  logic [NRET*PL-1:0]   lane_priv;
  logic                 trap_valid, ready;
  logic [IL-1:0]        trap_itype;
  logic [CL-1:0]        cause;
  logic [XLEN-1:0]      tval;
  logic [PL-1:0]        trap_priv;
  logic                 valid_o, ilastsize_o, overflow_o;
  logic [XLEN-1:0]      iaddr_o, tval_o;
  logic [IRL-1:0]       iretire_o;
  logic [IL-1:0]        itype_o;
  logic [CL-1:0]        cause_o;
  logic [PL-1:0]        priv_o;

  logic            t_lv [NRET];
  logic            t_c  [NRET];
  logic [XLEN-1:0] t_pc [NRET];
  logic [IL-1:0]   t_it [NRET];
  logic [PL-1:0]   t_pr [NRET];

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      lane_valid[k]               = t_lv[k];
      lane_compressed[k]          = t_c[k];
      lane_pc[k*XLEN +: XLEN]     = t_pc[k];
      lane_itype[k*IL +: IL]      = t_it[k];
      lane_priv[k*PL +: PL]       = t_pr[k];
    end
  end

  te_block_tracker #(
    .NRET(NRET), .XLEN(XLEN), .IRETIRE_LEN(IRL), .CAUSE_LEN(CL),
    .ITYPE_LEN(IL), .PRIV_LEN(PL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lane_valid_i(lane_valid), .lane_pc_i(lane_pc), .lane_compressed_i(lane_compressed),
    .lane_itype_i(lane_itype), .lane_priv_i(lane_priv),
    .trap_valid_i(trap_valid), .trap_itype_i(trap_itype), .cause_i(cause),
    .tval_i(tval), .trap_priv_i(trap_priv),
    .valid_o(valid_o), .ready_i(ready),
    .iaddr_o(iaddr_o), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
    .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: open block (base, halfword total, last size) and an ordered descriptor queue.
  desc_t           exp_q[$];
  bit              exp_ovf;
  bit              m_open;
  logic [XLEN-1:0] m_base;
  int              m_hw;
  bit              m_last;

  function automatic desc_t mk(logic [XLEN-1:0] a, int hw, bit l, int it, int ca,
                               logic [XLEN-1:0] tv, int pr);
    desc_t d;
    d.iaddr = a; d.iretire = IRL'(hw); d.ilastsize = l; d.itype = IL'(it);
    d.cause = CL'(ca); d.tval = tv; d.priv = PL'(pr);
    return d;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 0;
    m_open  = 0;
    m_base  = '0;
    m_hw    = 0;
    m_last  = 0;
  endtask

  task automatic model_cycle();
    desc_t gen[$];
    int    sz;
    for (int k = 0; k < NRET; k++) begin
      if (t_lv[k]) begin
        if (!m_open) begin m_open = 1; m_base = t_pc[k]; m_hw = 0; end
        sz = t_c[k] ? 1 : 2;
        if (m_hw + sz > (1 << IRL) - 1) begin
          gen.push_back(mk(m_base, m_hw, m_last, 0, 0, '0, int'(t_pr[k])));
          m_base = t_pc[k];
          m_hw   = 0;
        end
        m_hw   = m_hw + sz;
        m_last = !t_c[k];
        if (t_it[k] > 2) begin
          gen.push_back(mk(m_base, m_hw, m_last, int'(t_it[k]), 0, '0, int'(t_pr[k])));
          m_open = 0;
        end
      end
    end
    if (trap_valid) begin
      if (m_open)
        gen.push_back(mk(m_base, m_hw, m_last, int'(trap_itype), int'(cause),
                         (trap_itype == 2) ? '0 : tval, int'(trap_priv)));
      else
        gen.push_back(mk('0, 0, 0, int'(trap_itype), int'(cause),
                         (trap_itype == 2) ? '0 : tval, int'(trap_priv)));
      m_open = 0;
    end
    if (exp_q.size() > 0 && ready) void'(exp_q.pop_front());
    foreach (gen[i]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(gen[i]);
      else exp_ovf = 1;
    end
  endtask

  function automatic desc_t observed();
    desc_t d;
    d.iaddr = iaddr_o; d.iretire = iretire_o; d.ilastsize = ilastsize_o; d.itype = itype_o;
    d.cause = cause_o; d.tval = tval_o; d.priv = priv_o;
    return d;
  endfunction

  task automatic check_outputs(string tag);
    desc_t obs, exp;
    bit    ev;
    obs = observed();
    ev  = exp_q.size() > 0;
    exp = ev ? exp_q[0] : '0;
    checks++;
    assert (valid_o === ev) else begin
      failures++;
      $error("FAIL %s valid observed=%b expected=%b", tag, valid_o, ev);
    end
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s desc observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (overflow_o === exp_ovf) else begin
      failures++;
      $error("FAIL %s overflow observed=%b expected=%b", tag, overflow_o, exp_ovf);
    end
  endtask

  task automatic check_head(string tag, desc_t exp);
    desc_t obs;
    obs = observed();
    checks++;
    assert (valid_o === 1'b1 && obs === exp) else begin
      failures++;
      $error("FAIL %s head observed=%b/%h expected=1/%h", tag, valid_o, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NRET; k++) begin
      t_lv[k] = 0; t_c[k] = 0; t_pc[k] = '0; t_it[k] = '0; t_pr[k] = '0;
    end
    trap_valid = 0; trap_itype = '0; cause = '0; tval = '0; trap_priv = '0;
  endtask

  task automatic set_lane(int k, logic [XLEN-1:0] pc, bit c, int it, int pr);
    t_lv[k] = 1; t_pc[k] = pc; t_c[k] = c; t_it[k] = IL'(it); t_pr[k] = PL'(pr);
  endtask

  task automatic set_trap(int it, int ca, logic [XLEN-1:0] tv, int pr);
    trap_valid = 1; trap_itype = IL'(it); cause = CL'(ca); tval = tv; trap_priv = PL'(pr);
  endtask

  task automatic cycle(string tag);
    model_cycle();
    @(posedge clk);
    #1;
    check_outputs(tag);
    clear_inputs();
  endtask

  initial begin
    logic [XLEN-1:0] rpc;
    clear_inputs();
    ready = 1;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1;

    // 32-bit standard then 16-bit branch on the other lane next cycle
    set_lane(0, 64'h1000, 0, 0, 3); cycle("tp1_a");
    set_lane(1, 64'h1004, 1, 4, 3); cycle("tp1_b");
    check_head("tp1", mk(64'h1000, 3, 0, 4, 0, '0, 3));

    // jump closes a block, second lane opens another, exception closes it
    set_lane(0, 64'h2000, 0, 5, 3); set_lane(1, 64'h2004, 0, 0, 3); cycle("tp2_a");
    check_head("tp2a", mk(64'h2000, 2, 1, 5, 0, '0, 3));
    set_trap(1, 2, 64'hDEAD, 3); cycle("tp2_b");
    check_head("tp2b", mk(64'h2004, 2, 1, 1, 2, 64'hDEAD, 3));

    // interrupt with no open block: empty descriptor, tval forced to zero
    set_trap(2, 7, 64'hBEEF, 1); cycle("tp3");
    check_head("tp3", mk('0, 0, 0, 2, 7, '0, 1));
    cycle("tp3_drain");

    // saturation split at 15 halfwords; block reopens at the eighth instruction
    for (int c = 0; c < 4; c++) begin
      set_lane(0, 64'h3000 + 64'(8 * c), 0, 0, 3);
      set_lane(1, 64'h3004 + 64'(8 * c), 0, 0, 3);
      cycle("tp4_fill");
    end
    check_head("tp4_split", mk(64'h3000, 14, 1, 0, 0, '0, 3));
    set_lane(0, 64'h3020, 1, 3, 3); cycle("tp4_close");
    check_head("tp4_reopen", mk(64'h301C, 3, 0, 3, 0, '0, 3));
    cycle("tp4_drain");

    // back-pressure: nine descriptors into eight slots
    ready = 0;
    for (int i = 0; i < 9; i++) begin
      set_lane(0, 64'h4000 + 64'(2 * i), 1, 3, 3);
      cycle("tp5_fill");
    end
    checks++;
    assert (overflow_o === 1'b1) else begin
      failures++;
      $error("FAIL tp5_overflow observed=%b expected=1", overflow_o);
    end
    ready = 1;
    for (int i = 0; i < 8; i++) begin
      check_head("tp5_pop", mk(64'h4000 + 64'(2 * i), 1, 0, 3, 0, '0, 3));
      cycle("tp5_drain");
    end

    // asynchronous reset with an open block and three buffered descriptors
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 64'h6000 + 64'(4 * i), 0, 6, 2);
      cycle("tp6_fill");
    end
    set_lane(0, 64'h6100, 0, 0, 2); cycle("tp6_open");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    assert (valid_o === 1'b0 && overflow_o === 1'b0) else begin
      failures++;
      $error("FAIL tp6_reset observed=%b/%b expected=0/0", valid_o, overflow_o);
    end
    check_outputs("tp6_reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    ready = 1;
    set_lane(0, 64'h7000, 0, 0, 1); cycle("tp6_new_a");
    set_lane(0, 64'h7004, 0, 4, 1); cycle("tp6_new_b");
    check_head("tp6_new", mk(64'h7000, 4, 1, 4, 0, '0, 1));
    cycle("tp6_drain");

    // random traffic with gaps, splits, traps and back-pressure
    rpc = 64'h8000;
    for (int n = 0; n < 800; n++) begin
      ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NRET; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          int it;
          bit c;
          c  = $urandom_range(0, 1);
          it = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 7) : 0;
          set_lane(k, rpc, c, it, $urandom_range(0, 3));
          rpc = rpc + (c ? 64'd2 : 64'd4);
        end
      end
      if ($urandom_range(0, 9) == 0)
        set_trap($urandom_range(1, 2), $urandom_range(0, 31),
                 {$urandom(), $urandom()}, $urandom_range(0, 3));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
